// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares the memory data port between two valid/ready
//                    requesters (round-robin or fixed priority)
// Revision         : 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int unsigned DEPTH = 1024,
   parameter bit          FAIR  = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        r0_valid,
   input  logic        r0_we,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r0_wdata,
   output logic        r0_ready,
   output logic        r0_rvalid,
   output logic [31:0] r0_rdata,
   output logic        r0_err,
   input  logic        r1_valid,
   input  logic        r1_we,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r1_wdata,
   output logic        r1_ready,
   output logic        r1_rvalid,
   output logic [31:0] r1_rdata,
   output logic        r1_err,
   output logic        mem_rw,
   output logic [31:0] mem_ain,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [31:0] c_depth = 32'(DEPTH);

   state_t      state_q;
   logic        last_grant_q;
   logic        gnt_q;
   logic        err_q;
   logic        rd_q;
   logic        mem_rw_q;
   logic [31:0] mem_ain_q;
   logic [31:0] mem_din_q;
   logic        r0_rvalid_q;
   logic [31:0] r0_rdata_q;
   logic        r0_err_q;
   logic        r1_rvalid_q;
   logic [31:0] r1_rdata_q;
   logic        r1_err_q;

   logic        sel_r1;
   logic        accept;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_oor;

   // last_grant_q: 0 = r0 served last, 1 = r1 served last
   always_comb begin
      sel_r1    = r1_valid && (!r0_valid || (FAIR && !last_grant_q));
      accept    = (state_q == S_IDLE) && (r0_valid || r1_valid);
      req_we    = sel_r1 ? r1_we    : r0_we;
      req_addr  = sel_r1 ? r1_addr  : r0_addr;
      req_wdata = sel_r1 ? r1_wdata : r0_wdata;
      req_oor   = (req_addr >= c_depth);
      r0_ready  = (state_q == S_IDLE) && r0_valid && !sel_r1;
      r1_ready  = (state_q == S_IDLE) && sel_r1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         gnt_q        <= 1'b0;
         err_q        <= 1'b0;
         rd_q         <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_ain_q    <= 32'd0;
         mem_din_q    <= 32'd0;
         r0_rvalid_q  <= 1'b0;
         r0_rdata_q   <= 32'd0;
         r0_err_q     <= 1'b0;
         r1_rvalid_q  <= 1'b0;
         r1_rdata_q   <= 32'd0;
         r1_err_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  mem_ain_q    <= req_addr;
                  mem_din_q    <= req_wdata;
                  mem_rw_q     <= req_we && !req_oor;
                  err_q        <= req_oor;
                  rd_q         <= !req_we && !req_oor;
                  gnt_q        <= sel_r1;
                  last_grant_q <= sel_r1;
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mem_rw_q <= 1'b0;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               // mem_dout is valid here: memory registered the address last edge
               if (gnt_q) begin
                  r1_rvalid_q <= 1'b1;
                  r1_rdata_q  <= rd_q ? mem_dout : 32'd0;
                  r1_err_q    <= err_q;
               end else begin
                  r0_rvalid_q <= 1'b1;
                  r0_rdata_q  <= rd_q ? mem_dout : 32'd0;
                  r0_err_q    <= err_q;
               end
               state_q <= S_RESP;
            end
            S_RESP: begin
               r0_rvalid_q <= 1'b0;
               r1_rvalid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_rw    = mem_rw_q;
   assign mem_ain   = mem_ain_q;
   assign mem_din   = mem_din_q;
   assign r0_rvalid = r0_rvalid_q;
   assign r0_rdata  = r0_rdata_q;
   assign r0_err    = r0_err_q;
   assign r1_rvalid = r1_rvalid_q;
   assign r1_rdata  = r1_rdata_q;
   assign r1_err    = r1_err_q;

endmodule
`default_nettype wire
